// File: rtl/vram_arbiter.sv
// Arbitrates one single-port pixel RAM between scan-out reads and the drawing engine.
// Optional build macro ARB_FAIR_EN bounds how long a waiting draw can be held off during active video.
module vram_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int MAX_DISP_RUN = 8
) (
    input  logic              CLK_50MHz,
    input  logic              RESET_N,
    input  logic              VBLANK,
    input  logic              DISP_REQ,
    input  logic [ADDR_W-1:0] DISP_ADDR,
    output logic              DISP_GNT,
    output logic              DISP_DONE,
    output logic [DATA_W-1:0] DISP_RDATA,
    input  logic              DRAW_REQ,
    input  logic              DRAW_WE,
    input  logic [ADDR_W-1:0] DRAW_ADDR,
    input  logic [DATA_W-1:0] DRAW_WDATA,
    output logic              DRAW_GNT,
    output logic              DRAW_DONE,
    output logic [DATA_W-1:0] DRAW_RDATA,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                grant_disp, grant_draw;
    logic                force_draw;
    logic                sel_draw;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   disp_rdata_q, draw_rdata_q;
    logic                disp_done_q, draw_done_q;

`ifdef ARB_FAIR_EN
    logic [3:0] run_cnt;

    assign force_draw = (run_cnt >= 4'(MAX_DISP_RUN));

    // Counts display grants that went ahead of a waiting draw; saturates rather than wraps.
    always_ff @(posedge CLK_50MHz) begin
        if (!RESET_N) begin
            run_cnt <= '0;
        end else if (!DRAW_REQ || grant_draw) begin
            run_cnt <= '0;
        end else if (grant_disp && run_cnt != 4'hF) begin
            run_cnt <= run_cnt + 4'd1;
        end
    end
`else
    assign force_draw = 1'b0;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches inferred.
        state_nxt  = state;
        grant_disp = 1'b0;
        grant_draw = 1'b0;
        case (state)
            IDLE: begin
                if (DRAW_REQ && (VBLANK || force_draw || !DISP_REQ)) begin
                    grant_draw = 1'b1;
                end else if (DISP_REQ) begin
                    grant_disp = 1'b1;
                end
                if (grant_disp || grant_draw) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = DATA;
            DATA:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHz) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!RESET_N) begin
            state        <= IDLE;
            sel_draw     <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            disp_rdata_q <= '0;
            draw_rdata_q <= '0;
            disp_done_q  <= 1'b0;
            draw_done_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            disp_done_q <= (state == DATA) && !sel_draw;
            draw_done_q <= (state == DATA) && sel_draw;

            if (grant_disp || grant_draw) begin
                sel_draw <= grant_draw;
                we_q     <= grant_draw && DRAW_WE;
                addr_q   <= grant_draw ? DRAW_ADDR : DISP_ADDR;
                wdata_q  <= (grant_draw && DRAW_WE) ? DRAW_WDATA : '0;
            end

            // RAM data for the access issued last cycle is valid now; writes leave RDATA alone.
            if (state == DATA) begin
                if (!sel_draw) begin
                    disp_rdata_q <= MEM_RDATA;
                end else if (!we_q) begin
                    draw_rdata_q <= MEM_RDATA;
                end
            end
        end
    end

    assign MEM_EN     = (state == ISSUE);
    assign MEM_WE     = (state == ISSUE) && we_q;
    assign MEM_ADDR   = (state == ISSUE) ? addr_q : '0;
    assign MEM_WDATA  = (state == ISSUE) ? wdata_q : '0;
    assign DISP_GNT   = (state == ISSUE) && !sel_draw;
    assign DRAW_GNT   = (state == ISSUE) && sel_draw;
    assign DISP_DONE  = disp_done_q;
    assign DRAW_DONE  = draw_done_q;
    assign DISP_RDATA = disp_rdata_q;
    assign DRAW_RDATA = draw_rdata_q;

endmodule
